// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage pipeline interlock unit.
//   ctrl_state_t  : FSM state encoding (RUN, INTERLOCK, MEM_WAIT, ERROR)
//   ctrl_bundle_t : the five register enables and two bubble flushes
//   CTRL_*        : the four control patterns the controller can emit
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int REG_AW_DEFAULT      = 4;
    localparam int MEM_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INTERLOCK = 2'd1,
        MEM_WAIT  = 2'd2,
        ERROR     = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifof_en;
        logic ofex_en;
        logic exma_en;
        logic mawb_en;
        logic ifof_flush;
        logic ofex_flush;
    } ctrl_bundle_t;

    // Whole pipeline held (memory wait, error, reset).
    localparam ctrl_bundle_t CTRL_FREEZE    = 7'b00000_00;
    // Everything advances, no bubbles.
    localparam ctrl_bundle_t CTRL_RUN       = 7'b11111_00;
    // Taken branch: advance and squash the two younger instructions.
    localparam ctrl_bundle_t CTRL_BRANCH    = 7'b11111_11;
    // RAW stall: hold PC and IF/OF, drop a bubble into EX, let older drain.
    localparam ctrl_bundle_t CTRL_INTERLOCK = 7'b00111_01;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational RAW detector: flags when an OF-stage source register
// is the destination of a register-writing instruction still in EX, MA or WB.
// There is no forwarding, so any such match must stall. Register 0 is treated
// like every other register.
// Ports:
//   of_valid_i, of_rs1_i, of_rs2_i, of_rs1_used_i, of_rs2_used_i : OF sources
//   {ex,ma,wb}_valid_i, _rd_i, _iswb_i                           : writers
//   hazard_o                                                      : stall
// ---------------------------------------------------------------------------
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              of_valid_i,
    input  logic [REG_AW-1:0] of_rs1_i,
    input  logic [REG_AW-1:0] of_rs2_i,
    input  logic              of_rs1_used_i,
    input  logic              of_rs2_used_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_iswb_i,
    input  logic              ma_valid_i,
    input  logic [REG_AW-1:0] ma_rd_i,
    input  logic              ma_iswb_i,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_iswb_i,
    output logic              hazard_o
);

    logic ex_writes;
    logic ma_writes;
    logic wb_writes;
    logic rs1_match;
    logic rs2_match;

    assign ex_writes = ex_valid_i & ex_iswb_i;
    assign ma_writes = ma_valid_i & ma_iswb_i;
    assign wb_writes = wb_valid_i & wb_iswb_i;

    assign rs1_match = (ex_writes & (ex_rd_i == of_rs1_i))
                     | (ma_writes & (ma_rd_i == of_rs1_i))
                     | (wb_writes & (wb_rd_i == of_rs1_i));

    assign rs2_match = (ex_writes & (ex_rd_i == of_rs2_i))
                     | (ma_writes & (ma_rd_i == of_rs2_i))
                     | (wb_writes & (wb_rd_i == of_rs2_i));

    assign hazard_o = of_valid_i & ((of_rs1_used_i & rs1_match)
                                  | (of_rs2_used_i & rs2_match));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
// Interlock and sequencing unit for the IF/OF/EX/MA/WB pipeline. Produces the
// PC and inter-stage register enables/flushes from decoded stage fields,
// resolving RAW stalls, taken-branch squashes and data-memory wait states.
// Outputs are combinational from the current state and inputs; only the FSM,
// the memory timeout counter and the sticky error flag are registered.
//
// Ports:
//   clk, reset (async, active low)
//   of_*            : OF stage source registers
//   ex_/ma_/wb_*    : per-stage valid, destination index, writes-regfile
//   ex_branchtaken  : EX resolved a taken control transfer
//   ma_memop, mem_ack : data memory access in MA and its completion
//   pc_en, ifof_en, ofex_en, exma_en, mawb_en : register enables
//   ifof_flush, ofex_flush : load a bubble (flush beats enable)
//   mem_req, mem_err, ctrl_state
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance
// counters cnt_cycles, cnt_interlock, cnt_memwait, cnt_flush (CNT_W bits).
// ---------------------------------------------------------------------------
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEFAULT,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              of_valid,
    input  logic [REG_AW-1:0] of_rs1,
    input  logic [REG_AW-1:0] of_rs2,
    input  logic              of_rs1_used,
    input  logic              of_rs2_used,
    input  logic              ex_valid,
    input  logic              ma_valid,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ma_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_iswb,
    input  logic              ma_iswb,
    input  logic              wb_iswb,
    input  logic              ex_branchtaken,
    input  logic              ma_memop,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              ifof_en,
    output logic              ofex_en,
    output logic              exma_en,
    output logic              mawb_en,
    output logic              ifof_flush,
    output logic              ofex_flush,
    output logic              mem_req,
    output logic              mem_err,
    output logic [1:0]        ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_cycles,
    output logic [CNT_W-1:0]  cnt_interlock,
    output logic [CNT_W-1:0]  cnt_memwait,
    output logic [CNT_W-1:0]  cnt_flush
`endif
);

    localparam logic [1:0] ST_RUN       = RUN;
    localparam logic [1:0] ST_INTERLOCK = INTERLOCK;
    localparam logic [1:0] ST_MEM_WAIT  = MEM_WAIT;
    localparam logic [1:0] ST_ERROR     = ERROR;

    // Wide enough to hold MEM_TIMEOUT itself; the counter never passes it
    // because reaching it moves the FSM into ERROR, where it is frozen.
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]       state_q,   state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W-1:0] tmo_inc;
    logic             mem_err_q, mem_err_d;

    logic             hazard;
    logic             mem_req_raw;
    logic             mem_stall;
    ctrl_bundle_t     ctl;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .of_valid_i    (of_valid),
        .of_rs1_i      (of_rs1),
        .of_rs2_i      (of_rs2),
        .of_rs1_used_i (of_rs1_used),
        .of_rs2_used_i (of_rs2_used),
        .ex_valid_i    (ex_valid),
        .ex_rd_i       (ex_rd),
        .ex_iswb_i     (ex_iswb),
        .ma_valid_i    (ma_valid),
        .ma_rd_i       (ma_rd),
        .ma_iswb_i     (ma_iswb),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_iswb_i     (wb_iswb),
        .hazard_o      (hazard)
    );

    // Memory handshake: the request is level-based and stays up for as long
    // as the access sits in a frozen MA stage. ERROR withdraws it.
    assign mem_req_raw = ma_valid & ma_memop & (state_q != ST_ERROR);
    assign mem_stall   = mem_req_raw & ~mem_ack;
    assign tmo_inc     = tmo_cnt_q + TMO_W'(1);

    // Priority: ERROR > mem_stall > taken branch > RAW hazard > normal.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        mem_err_d = mem_err_q;
        ctl       = CTRL_FREEZE;

        if (state_q != ST_ERROR) begin
            if (mem_stall) begin
                // Freeze everything, including a taken branch waiting in EX.
                tmo_cnt_d = tmo_inc;
                if (tmo_inc >= TMO_W'(MEM_TIMEOUT)) begin
                    state_d   = ST_ERROR;
                    mem_err_d = 1'b1;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end else begin
                tmo_cnt_d = '0;
                if (ex_branchtaken) begin
                    // The instruction in OF is squashed, so its hazard is moot.
                    ctl     = CTRL_BRANCH;
                    state_d = ST_RUN;
                end else if (hazard) begin
                    ctl     = CTRL_INTERLOCK;
                    state_d = ST_INTERLOCK;
                end else begin
                    ctl     = CTRL_RUN;
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Outputs are gated with reset so an in-flight access is abandoned the
    // moment reset asserts, without waiting for a clock edge.
    assign pc_en      = reset & ctl.pc_en;
    assign ifof_en    = reset & ctl.ifof_en;
    assign ofex_en    = reset & ctl.ofex_en;
    assign exma_en    = reset & ctl.exma_en;
    assign mawb_en    = reset & ctl.mawb_en;
    assign ifof_flush = reset & ctl.ifof_flush;
    assign ofex_flush = reset & ctl.ofex_flush;
    assign mem_req    = reset & mem_req_raw;
    assign mem_err    = mem_err_q;
    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic             live;
    logic             ev_interlock;
    logic             ev_flush;
    logic [CNT_W-1:0] cnt_cycles_q;
    logic [CNT_W-1:0] cnt_interlock_q;
    logic [CNT_W-1:0] cnt_memwait_q;
    logic [CNT_W-1:0] cnt_flush_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             hit);
        if (hit && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // Events mirror the priority chain above; nothing counts in ERROR.
    assign live         = (state_q != ST_ERROR);
    assign ev_interlock = ~mem_stall & ~ex_branchtaken & hazard;
    assign ev_flush     = ~mem_stall & ex_branchtaken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_cycles_q    <= '0;
            cnt_interlock_q <= '0;
            cnt_memwait_q   <= '0;
            cnt_flush_q     <= '0;
        end else if (live) begin
            cnt_cycles_q    <= sat_inc(cnt_cycles_q, 1'b1);
            cnt_interlock_q <= sat_inc(cnt_interlock_q, ev_interlock);
            cnt_memwait_q   <= sat_inc(cnt_memwait_q, mem_stall);
            cnt_flush_q     <= sat_inc(cnt_flush_q, ev_flush);
        end
    end

    assign cnt_cycles    = cnt_cycles_q;
    assign cnt_interlock = cnt_interlock_q;
    assign cnt_memwait   = cnt_memwait_q;
    assign cnt_flush     = cnt_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Directed bench for pipeline_hazard_controller. Each cycle the expected
// output word is pushed when inputs are driven and popped at the falling
// edge, where the combinational outputs are compared.
// Output word: {ctrl_state[1:0], mem_err, mem_req, pc_en, ifof_en, ofex_en,
//               exma_en, mawb_en, ifof_flush, ofex_flush}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam logic [6:0] C_RUN = 7'b11111_00;
    localparam logic [6:0] C_HAZ = 7'b00111_01;
    localparam logic [6:0] C_BR  = 7'b11111_11;
    localparam logic [6:0] C_FRZ = 7'b00000_00;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       of_valid, of_rs1_used, of_rs2_used;
    logic [3:0] of_rs1, of_rs2;
    logic       ex_valid, ma_valid, wb_valid;
    logic [3:0] ex_rd, ma_rd, wb_rd;
    logic       ex_iswb, ma_iswb, wb_iswb;
    logic       ex_branchtaken, ma_memop, mem_ack;
    logic       pc_en, ifof_en, ofex_en, exma_en, mawb_en;
    logic       ifof_flush, ofex_flush, mem_req, mem_err;
    logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_cycles, cnt_interlock, cnt_memwait, cnt_flush;
`endif

    pipeline_hazard_controller dut (
        .clk            (clk),
        .reset          (reset),
        .of_valid       (of_valid),
        .of_rs1         (of_rs1),
        .of_rs2         (of_rs2),
        .of_rs1_used    (of_rs1_used),
        .of_rs2_used    (of_rs2_used),
        .ex_valid       (ex_valid),
        .ma_valid       (ma_valid),
        .wb_valid       (wb_valid),
        .ex_rd          (ex_rd),
        .ma_rd          (ma_rd),
        .wb_rd          (wb_rd),
        .ex_iswb        (ex_iswb),
        .ma_iswb        (ma_iswb),
        .wb_iswb        (wb_iswb),
        .ex_branchtaken (ex_branchtaken),
        .ma_memop       (ma_memop),
        .mem_ack        (mem_ack),
        .pc_en          (pc_en),
        .ifof_en        (ifof_en),
        .ofex_en        (ofex_en),
        .exma_en        (exma_en),
        .mawb_en        (mawb_en),
        .ifof_flush     (ifof_flush),
        .ofex_flush     (ofex_flush),
        .mem_req        (mem_req),
        .mem_err        (mem_err),
        .ctrl_state     (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .cnt_cycles     (cnt_cycles),
        .cnt_interlock  (cnt_interlock),
        .cnt_memwait    (cnt_memwait),
        .cnt_flush      (cnt_flush)
`endif
    );

    // Scoreboard
    logic [10:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [10:0] mk(input logic [1:0] st, input logic err,
                                       input logic req, input logic [6:0] ctl);
        return {st, err, req, ctl};
    endfunction

    function automatic logic [10:0] observed();
        return {ctrl_state, mem_err, mem_req, pc_en, ifof_en, ofex_en,
                exma_en, mawb_en, ifof_flush, ofex_flush};
    endfunction

    task automatic check_now(input string tag);
        logic [10:0] obs;
        logic [10:0] exp_v;
        obs = observed();
        total_cnt++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %b expected <queued value missing>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) begin
                pass_cnt++;
            end else begin
                $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Driver tasks: inputs are applied 1 time unit after the rising edge,
    // outputs are sampled at the falling edge.
    task automatic cycle(input string tag, input logic [10:0] exp_v);
        exp_q.push_back(exp_v);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        of_valid = 0; of_rs1 = 0; of_rs2 = 0; of_rs1_used = 0; of_rs2_used = 0;
        ex_valid = 0; ma_valid = 0; wb_valid = 0;
        ex_rd = 0; ma_rd = 0; wb_rd = 0;
        ex_iswb = 0; ma_iswb = 0; wb_iswb = 0;
        ex_branchtaken = 0; ma_memop = 0; mem_ack = 0;
    endtask

    // r3 writer drains EX -> MA -> WB while OF (reading r3) is held.
    task automatic hazard_run();
        of_valid = 1; of_rs1 = 4'd3; of_rs1_used = 1;
        of_rs2 = 4'($urandom_range(4, 15)); of_rs2_used = 1;
        ex_valid = 1; ex_iswb = 1; ex_rd = 4'd3;
        cycle("haz_ex", mk(2'd0, 0, 0, C_HAZ));
        ex_valid = 0; ex_iswb = 0;
        ma_valid = 1; ma_iswb = 1; ma_rd = 4'd3;
        cycle("haz_ma", mk(2'd1, 0, 0, C_HAZ));
        ma_valid = 0; ma_iswb = 0;
        wb_valid = 1; wb_iswb = 1; wb_rd = 4'd3;
        cycle("haz_wb", mk(2'd1, 0, 0, C_HAZ));
        wb_valid = 0; wb_iswb = 0;
        cycle("haz_free", mk(2'd1, 0, 0, C_RUN));
        clear_inputs();
        cycle("haz_run", mk(2'd0, 0, 0, C_RUN));
    endtask

    // Memory access in MA acknowledged after 'wait_cycles' stall cycles.
    task automatic mem_run(input int wait_cycles, input logic br);
        ma_valid = 1; ma_memop = 1; mem_ack = 0; ex_branchtaken = br;
        for (int i = 0; i < wait_cycles; i++) begin
            cycle("mem_stall", mk((i == 0) ? 2'd0 : 2'd2, 0, 1, C_FRZ));
        end
        mem_ack = 1;
        cycle("mem_ack", mk(2'd2, 0, 1, br ? C_BR : C_RUN));
        clear_inputs();
        cycle("mem_after", mk(2'd0, 0, 0, C_RUN));
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        // Activity on the inputs must not leak out while reset is low.
        ma_valid = 1; ma_memop = 1; ex_branchtaken = 1;
        cycle("reset_out", mk(2'd0, 0, 0, C_FRZ));
        reset = 1;
        clear_inputs();
        cycle("idle", mk(2'd0, 0, 0, C_RUN));

        // RAW stall through all three writer stages.
        hazard_run();

        // Register 0 hazards too (rs2 vs MA writer).
        of_valid = 1; of_rs2 = 4'd0; of_rs2_used = 1;
        ma_valid = 1; ma_iswb = 1; ma_rd = 4'd0;
        cycle("r0_haz", mk(2'd0, 0, 0, C_HAZ));
        ma_iswb = 0;
        cycle("no_iswb", mk(2'd1, 0, 0, C_RUN));
        clear_inputs();
        of_valid = 1; of_rs1 = 4'd5; of_rs1_used = 0;
        wb_valid = 1; wb_iswb = 1; wb_rd = 4'd5;
        cycle("rs_unused", mk(2'd0, 0, 0, C_RUN));
        of_rs1_used = 1; of_valid = 0;
        cycle("of_invalid", mk(2'd0, 0, 0, C_RUN));
        clear_inputs();
        cycle("idle2", mk(2'd0, 0, 0, C_RUN));

        // Taken branch beats a simultaneous hazard.
        of_valid = 1; of_rs1 = 4'd3; of_rs1_used = 1;
        ex_valid = 1; ex_iswb = 1; ex_rd = 4'd3; ex_branchtaken = 1;
        cycle("br_haz", mk(2'd0, 0, 0, C_BR));
        clear_inputs();
        cycle("br_after", mk(2'd0, 0, 0, C_RUN));

        // Memory waits: plain store, then a held branch released on ack.
        mem_run(4, 1'b0);
        mem_run($urandom_range(1, 6), 1'b1);

        // Timeout: never acknowledged.
        ma_valid = 1; ma_memop = 1;
        for (int i = 0; i < 15; i++) begin
            cycle("tmo_wait", mk((i == 0) ? 2'd0 : 2'd2, 0, 1, C_FRZ));
        end
        mem_ack = 1; ex_branchtaken = 1;
        of_valid = 1; of_rs1 = 4'd3; of_rs1_used = 1;
        ex_valid = 1; ex_iswb = 1; ex_rd = 4'd3;
        cycle("err_enter", mk(2'd3, 1, 0, C_FRZ));
        clear_inputs();
        cycle("err_hold", mk(2'd3, 1, 0, C_FRZ));
        reset = 0;
        cycle("err_reset", mk(2'd0, 0, 0, C_FRZ));
        reset = 1;
        cycle("err_released", mk(2'd0, 0, 0, C_RUN));

        // Reset in the middle of MEM_WAIT drops mem_req at once.
        ma_valid = 1; ma_memop = 1;
        cycle("mw_first", mk(2'd0, 0, 1, C_FRZ));
        cycle("mw_wait", mk(2'd2, 0, 1, C_FRZ));
        #2;
        reset = 0;
        #1;
        exp_q.push_back(mk(2'd0, 0, 0, C_FRZ));
        check_now("mw_async_reset");
        clear_inputs();
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        cycle("mw_after_reset", mk(2'd0, 0, 0, C_RUN));

`ifdef HAZARD_PERF_CNT_EN
        reset = 0;
        #10;
        reset = 1;
        check_val("cnt_clear", cnt_interlock, 32'd0);
        cycle("perf_idle", mk(2'd0, 0, 0, C_RUN));
        hazard_run();
        mem_run(4, 1'b0);
        check_val("cnt_interlock", cnt_interlock, 32'd3);
        check_val("cnt_memwait", cnt_memwait, 32'd4);
        check_val("cnt_flush", cnt_flush, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
